mem_stage_lsu: RTL and testbench
================================

// Module: mem_stage_lsu
// PURPOSE
//  MEM-stage load/store unit of the 5-stage RV32I pipeline. Consumes the EX/MEM register outputs
//  and runs a req/gnt/rvalid handshake with data memory. Performs byte-lane steering and load
//  sign/zero extension, and drives StallM so the hazard unit freezes upstream stages while an
//  access is outstanding. ReadDataM feeds the MEM/WB register.
// PARAMETERS
//  TIMEOUT   16   cycles allowed in WAIT_GNT or WAIT_RVALID before abort (>=2)
// PORTS
//  clk          in   1   clock
//  reset        in   1   reset, asynchronous, active-high
//  ALUResultM   in   32  effective address
//  WriteDataM   in   32  store data (rs2), unshifted
//  ResultSrcM   in   2   2'b01 = load
//  MemWriteM    in   1   store
//  Funct3M      in   3   access size/sign (RV32I load/store funct3)
//  mem_req      out  1   request valid
//  mem_we       out  1   1=write
//  mem_addr     out  32  {ALUResultM[31:2],2'b00}
//  mem_be       out  4   byte enables
//  mem_wdata    out  32  lane-shifted store data
//  mem_gnt      in   1   request accepted (same cycle as mem_req)
//  mem_rvalid   in   1   read data valid (>=1 cycle after gnt)
//  mem_rdata    in   32  read word
//  ReadDataM    out  32  extended load result
//  StallM       out  1   hold IF..EX/MEM, bubble MEM/WB
//  BusErrM      out  1   1-cycle pulse: access aborted on timeout
//  MisalignM    out  1   1-cycle pulse: misaligned access (see CONFIGURATION)
// BEHAVIOUR
//  - access = MemWriteM | (ResultSrcM==2'b01); both set at once -> treated as store.
//  - FSM: IDLE, WAIT_GNT, WAIT_RVALID; 5-bit wait counter cnt, cleared on every transition.
//  - IDLE: access -> mem_req=1 combinationally. gnt: store done (no stall); load -> WAIT_RVALID.
//    No gnt -> WAIT_GNT.
//  - WAIT_GNT: mem_req=1 with addr/we/be/wdata stable; gnt -> store done -> IDLE, load -> WAIT_RVALID.
//  - WAIT_RVALID: mem_req=0; rvalid -> ReadDataM valid that cycle, StallM=0, -> IDLE.
//  - StallM = access & !done-this-cycle. Min latency: store 0 stall cycles, load 1 stall cycle.
//  - Timeout: cnt==TIMEOUT-1 in a wait state without the awaited event -> BusErrM=1, StallM=0,
//    ReadDataM=0, mem_req=0, -> IDLE. A late rvalid/gnt arriving in IDLE is ignored.
//  - Bytes: SB be=4'b0001<<a[1:0], wdata={4{wd[7:0]}}. SH be=4'b0011<<{a[1],1'b0},
//    wdata={2{wd[15:0]}}. SW be=4'b1111, wdata=wd.
//  - Loads: LB/LBU select byte a[1:0], sign/zero-extend. LH/LHU select half a[1], sign/zero-extend.
//    LW passes the word. Undefined funct3 -> ReadDataM=0, be=0, no request.
//  - ReadDataM combinational from mem_rdata in completion cycle; 0 otherwise.
//  - Reset (any time, incl. mid-access): state=IDLE, cnt=0; mem_req, mem_we, mem_be, StallM,
//    BusErrM, MisalignM, ReadDataM all 0 while reset high. The in-flight access is dropped, not replayed.
// CONFIGURATION
//  MISALIGN_TRAP_EN defined: misaligned access (half with a[0]=1; word with a[1:0]!=0) issues
//    no request, MisalignM=1, StallM=0, ReadDataM=0 for that cycle.
//  Undefined: MisalignM tied 0; the low address bits the access size cannot use are ignored
//    (half uses a[1], word uses none) and the access proceeds.
// TESTING
//  1 SW a=0x100 wd=0xDEADBEEF, gnt same cycle -> be=4'b1111, addr=0x100, StallM=0 all cycles.
//  2 LB a=0x103, gnt cycle0, rvalid cycle2 rdata=0x80xxxxxx -> StallM=1 cycles 0-1,
//    ReadDataM=0xFFFFFF80 cycle2; LBU -> 0x00000080.
//  3 SH a=0x102 wd=0x1234, gnt delayed 3 cycles -> req/addr/be=4'b1100/wdata=0x12341234 stable,
//    StallM=1 for 3 cycles.
//  4 LW, no rvalid, TIMEOUT=16 -> BusErrM pulse 16 cycles after gnt, StallM drops, late rvalid ignored.
//  5 LW a=0x102: with MISALIGN_TRAP_EN -> MisalignM=1, mem_req=0; without -> addr=0x100, normal load.
//  6 reset asserted in WAIT_RVALID -> mem_req/StallM=0 immediately, state IDLE, next access normal.

Source files
------------

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: MEM-stage load/store unit for the 5-stage RV32I pipeline.
// It runs a req/gnt/rvalid handshake with data memory and steers store bytes onto lanes.
// It sign- or zero-extends load data and raises StallM while an access is outstanding.
// The optional misaligned-access trap is compiled in with `define MISALIGN_TRAP_EN.
module mem_stage_lsu #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] ALUResultM,
   input  logic [31:0] WriteDataM,
   input  logic [1:0]  ResultSrcM,
   input  logic        MemWriteM,
   input  logic [2:0]  Funct3M,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_gnt,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   output logic [31:0] ReadDataM,
   output logic        StallM,
   output logic        BusErrM,
   output logic        MisalignM
);

   typedef enum logic [1:0] {
      IDLE,
      WAIT_GNT,
      WAIT_RVALID
   } state_t;

   localparam logic [4:0] CNT_LAST = 5'(TIMEOUT - 1);

   state_t      state, state_next;
   logic [4:0]  cnt, cnt_next;

   logic        is_store, is_load, f3_ok, trap, access;
   logic [3:0]  be;
   logic [31:0] wdata, load_ext;
   logic        req, stall, bus_err, load_done;

   // Decode the access: kind, legal funct3, optional misalignment trap.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can infer a latch.
      is_store = MemWriteM;
      is_load  = !MemWriteM && (ResultSrcM == 2'b01);
      if (is_store)
         f3_ok = Funct3M inside {3'b000, 3'b001, 3'b010};
      else
         f3_ok = Funct3M inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      trap = 1'b0;
`ifdef MISALIGN_TRAP_EN
      if ((is_store || is_load) && f3_ok) begin
         if (Funct3M[1:0] == 2'b01 && ALUResultM[0])
            trap = 1'b1;
         else if (Funct3M[1:0] == 2'b10 && ALUResultM[1:0] != 2'b00)
            trap = 1'b1;
      end
`endif
      access = (is_store || is_load) && f3_ok && !trap;
   end

   // Byte-lane steering for stores and byte enables for all accesses.
   always_comb begin
      be    = 4'b0000;
      wdata = WriteDataM;
      case (Funct3M[1:0])
         2'b00: begin
            be    = 4'b0001 << ALUResultM[1:0];
            wdata = {4{WriteDataM[7:0]}};
         end
         2'b01: begin
            be    = 4'b0011 << {ALUResultM[1], 1'b0};
            wdata = {2{WriteDataM[15:0]}};
         end
         default: begin
            be    = 4'b1111;
            wdata = WriteDataM;
         end
      endcase
   end

   // Load data selection and sign/zero extension from the returned word.
   always_comb begin
      logic [7:0]  sel_byte;
      logic [15:0] sel_half;
      sel_byte = 8'h00;
      case (ALUResultM[1:0])
         2'b00:   sel_byte = mem_rdata[7:0];
         2'b01:   sel_byte = mem_rdata[15:8];
         2'b10:   sel_byte = mem_rdata[23:16];
         default: sel_byte = mem_rdata[31:24];
      endcase
      sel_half = ALUResultM[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      case (Funct3M)
         3'b000:  load_ext = {{24{sel_byte[7]}}, sel_byte};
         3'b001:  load_ext = {{16{sel_half[15]}}, sel_half};
         3'b010:  load_ext = mem_rdata;
         3'b100:  load_ext = {24'h000000, sel_byte};
         3'b101:  load_ext = {16'h0000, sel_half};
         default: load_ext = 32'h0000_0000;
      endcase
   end

   // Handshake FSM: next state, wait counter and raw request/stall/error decisions.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      req        = 1'b0;
      stall      = 1'b0;
      bus_err    = 1'b0;
      load_done  = 1'b0;
      case (state)
         IDLE: begin
            if (access) begin
               req = 1'b1;
               if (mem_gnt) begin
                  if (!is_store) begin
                     state_next = WAIT_RVALID;
                     stall      = 1'b1;
                  end
               end else begin
                  state_next = WAIT_GNT;
                  stall      = 1'b1;
               end
            end
         end
         WAIT_GNT: begin
            if (mem_gnt) begin
               req = 1'b1;
               if (is_store) begin
                  state_next = IDLE;
               end else begin
                  state_next = WAIT_RVALID;
                  stall      = 1'b1;
               end
            end else if (cnt == CNT_LAST) begin
               bus_err    = 1'b1;
               state_next = IDLE;
            end else begin
               req      = 1'b1;
               stall    = 1'b1;
               cnt_next = cnt + 5'd1;
            end
         end
         WAIT_RVALID: begin
            if (mem_rvalid) begin
               load_done  = 1'b1;
               state_next = IDLE;
            end else if (cnt == CNT_LAST) begin
               bus_err    = 1'b1;
               state_next = IDLE;
            end else begin
               stall    = 1'b1;
               cnt_next = cnt + 5'd1;
            end
         end
         default: state_next = IDLE;
      endcase
      if (state_next != state)
         cnt_next = 5'd0;
   end

   // State and wait counter registers; reset drops any in-flight access.
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (reset) begin
         state <= IDLE;
         cnt   <= 5'd0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   // Output drive: everything that matters to the pipeline is forced low while reset is high.
   always_comb begin
      mem_req   = req && !reset;
      mem_we    = mem_req && is_store;
      mem_addr  = {ALUResultM[31:2], 2'b00};
      mem_be    = mem_req ? be : 4'b0000;
      mem_wdata = wdata;
      StallM    = stall && !reset;
      BusErrM   = bus_err && !reset;
      ReadDataM = (load_done && !reset) ? load_ext : 32'h0000_0000;
      MisalignM = trap && (state == IDLE) && !reset;
   end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: directed and randomized accesses against a timeline/arithmetic model.
module tb_mem_stage_lsu;

   localparam int TIMEOUT = 16;
`ifdef MISALIGN_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] ALUResultM, WriteDataM, mem_addr, mem_wdata, mem_rdata, ReadDataM;
   logic [1:0]  ResultSrcM;
   logic        MemWriteM, mem_req, mem_we, mem_gnt, mem_rvalid, StallM, BusErrM, MisalignM;
   logic [2:0]  Funct3M;
   logic [3:0]  mem_be;

   int checks   = 0;
   int failures = 0;

   mem_stage_lsu #(.TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset),
      .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .ResultSrcM(ResultSrcM),
      .MemWriteM(MemWriteM), .Funct3M(Funct3M),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
      .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .ReadDataM(ReadDataM), .StallM(StallM), .BusErrM(BusErrM), .MisalignM(MisalignM)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] a);
      int lane;
      lane = int'(a[1:0]);
      case (f3[1:0])
         2'd0:    return 4'(1 << lane);
         2'd1:    return (lane >= 2) ? 4'hC : 4'h3;
         default: return 4'hF;
      endcase
   endfunction

   function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
      case (f3[1:0])
         2'd0:    return (wd & 32'hFF) * 32'h0101_0101;
         2'd1:    return (wd & 32'hFFFF) * 32'h0001_0001;
         default: return wd;
      endcase
   endfunction

   function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] rd);
      logic [31:0] v;
      case (f3)
         3'd0, 3'd4: begin
            v = (rd >> (8 * int'(a[1:0]))) & 32'hFF;
            if (f3 == 3'd0 && v >= 32'd128) v = v | 32'hFFFF_FF00;
         end
         3'd1, 3'd5: begin
            v = (rd >> (16 * int'(a[1]))) & 32'hFFFF;
            if (f3 == 3'd1 && v >= 32'd32768) v = v | 32'hFFFF_0000;
         end
         3'd2:    v = rd;
         default: v = 32'h0;
      endcase
      return v;
   endfunction

   task automatic idle_inputs();
      MemWriteM  = 1'b0;
      ResultSrcM = 2'b00;
      Funct3M    = 3'b000;
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
   endtask

   // Called just after a rising edge. g = cycle of gnt, r = cycles from gnt to rvalid.
   task automatic run_access(input string name, input logic we, input logic [1:0] rsrc,
                             input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                             input int g, input int r, input logic [31:0] rd, input bit late);
      bit is_store, is_load, valid, mis, granted, err;
      int last;
      is_store = we;
      is_load  = !we && rsrc == 2'b01;
      valid    = is_store ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      mis      = (f3[1:0] == 2'd1 && a[0]) || (f3[1:0] == 2'd2 && a[1:0] != 2'b00);
      MemWriteM  = we;
      ResultSrcM = rsrc;
      Funct3M    = f3;
      ALUResultM = a;
      WriteDataM = wd;
      if (!(is_store || is_load) || !valid || (TRAP && mis)) begin
         mem_gnt   = 1'b0;
         mem_rvalid = 1'b0;
         mem_rdata = $urandom;
         @(negedge clk);
         check({name, ".noreq.req"}, mem_req, 0);
         check({name, ".noreq.stall"}, StallM, 0);
         check({name, ".noreq.be"}, mem_be, 0);
         check({name, ".noreq.rdata"}, ReadDataM, 0);
         check({name, ".noreq.buserr"}, BusErrM, 0);
         check({name, ".noreq.misalign"}, MisalignM,
               32'((is_store || is_load) && valid && TRAP && mis));
         @(posedge clk); #1;
         idle_inputs();
         return;
      end
      granted = g <= TIMEOUT;
      if (!granted) begin
         err  = 1'b1;
         last = TIMEOUT;
      end else if (is_store) begin
         err  = 1'b0;
         last = g;
      end else if (r > TIMEOUT) begin
         err  = 1'b1;
         last = g + TIMEOUT;
      end else begin
         err  = 1'b0;
         last = g + r;
      end
      for (int c = 0; c <= last; c++) begin
         bit exp_req;
         mem_gnt    = (c == g);
         mem_rvalid = is_load && granted && (c == g + r);
         mem_rdata  = mem_rvalid ? rd : $urandom;
         @(negedge clk);
         exp_req = (c <= (granted ? g : TIMEOUT)) && !(c == last && !granted);
         check($sformatf("%s.c%0d.req", name, c), mem_req, 32'(exp_req));
         check($sformatf("%s.c%0d.stall", name, c), StallM, 32'(c < last));
         check($sformatf("%s.c%0d.buserr", name, c), BusErrM, 32'(err && c == last));
         check($sformatf("%s.c%0d.rdata", name, c), ReadDataM,
               (is_load && !err && c == last) ? model_load(f3, a, rd) : 32'h0);
         check($sformatf("%s.c%0d.misalign", name, c), MisalignM, 0);
         if (exp_req) begin
            check($sformatf("%s.c%0d.addr", name, c), mem_addr, a & 32'hFFFF_FFFC);
            check($sformatf("%s.c%0d.be", name, c), mem_be, model_be(f3, a));
            check($sformatf("%s.c%0d.we", name, c), mem_we, 32'(is_store));
            if (is_store)
               check($sformatf("%s.c%0d.wdata", name, c), mem_wdata, model_wdata(f3, wd));
         end
         @(posedge clk); #1;
      end
      idle_inputs();
      if (late && err) begin
         mem_gnt    = 1'b1;
         mem_rvalid = 1'b1;
         mem_rdata  = 32'hFFFF_FFFF;
         @(negedge clk);
         check({name, ".late.req"}, mem_req, 0);
         check({name, ".late.stall"}, StallM, 0);
         check({name, ".late.rdata"}, ReadDataM, 0);
         check({name, ".late.buserr"}, BusErrM, 0);
         @(posedge clk); #1;
         idle_inputs();
      end
   endtask

   initial begin
      // Reset with a store presented: combinational request must still be held off.
      reset      = 1'b1;
      ALUResultM = 32'h100;
      WriteDataM = 32'h0;
      mem_rdata  = 32'h0;
      idle_inputs();
      MemWriteM  = 1'b1;
      Funct3M    = 3'b010;
      mem_rvalid = 1'b1;
      #1;
      check("rst.req", mem_req, 0);
      check("rst.we", mem_we, 0);
      check("rst.be", mem_be, 0);
      check("rst.stall", StallM, 0);
      check("rst.buserr", BusErrM, 0);
      check("rst.misalign", MisalignM, 0);
      check("rst.rdata", ReadDataM, 0);
      @(posedge clk); #1;
      idle_inputs();
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;

      run_access("sw",   1'b1, 2'b00, 3'b010, 32'h100, 32'hDEAD_BEEF, 0, 1, 32'h0, 1'b0);
      run_access("lb",   1'b0, 2'b01, 3'b000, 32'h103, 32'h0, 0, 2, 32'h8012_3456, 1'b0);
      run_access("lbu",  1'b0, 2'b01, 3'b100, 32'h103, 32'h0, 0, 2, 32'h8012_3456, 1'b0);
      run_access("sh",   1'b1, 2'b00, 3'b001, 32'h102, 32'h0000_1234, 3, 1, 32'h0, 1'b0);
      run_access("lw_to", 1'b0, 2'b01, 3'b010, 32'h200, 32'h0, 0, 100, 32'h0, 1'b1);
      run_access("lw_mis", 1'b0, 2'b01, 3'b010, 32'h102, 32'h0, 0, 1, 32'hCAFE_F00D, 1'b0);
      run_access("sh_mis", 1'b1, 2'b00, 3'b001, 32'h105, 32'hABCD, 1, 1, 32'h0, 1'b0);
      run_access("sw_g16", 1'b1, 2'b00, 3'b010, 32'h40, 32'h1111_2222, 16, 1, 32'h0, 1'b0);
      run_access("sw_g17", 1'b1, 2'b00, 3'b010, 32'h40, 32'h1111_2222, 17, 1, 32'h0, 1'b1);
      run_access("lw_r16", 1'b0, 2'b01, 3'b010, 32'h44, 32'h0, 2, 16, 32'h1234_5678, 1'b0);
      run_access("both",   1'b1, 2'b01, 3'b000, 32'h301, 32'h0000_00A5, 1, 1, 32'h0, 1'b0);
      run_access("badf3",  1'b0, 2'b01, 3'b011, 32'h10, 32'h0, 0, 1, 32'h0, 1'b0);
      run_access("badsf3", 1'b1, 2'b00, 3'b100, 32'h10, 32'h0, 0, 1, 32'h0, 1'b0);

      // Reset asserted while a load waits for rvalid.
      MemWriteM  = 1'b0;
      ResultSrcM = 2'b01;
      Funct3M    = 3'b010;
      ALUResultM = 32'h300;
      mem_gnt    = 1'b1;
      @(negedge clk);
      check("rstmid.c0.req", mem_req, 1);
      check("rstmid.c0.stall", StallM, 1);
      @(posedge clk); #1;
      mem_gnt = 1'b0;
      @(negedge clk);
      check("rstmid.c1.stall", StallM, 1);
      reset      = 1'b1;
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h5555_AAAA;
      #1;
      check("rstmid.req", mem_req, 0);
      check("rstmid.stall", StallM, 0);
      check("rstmid.rdata", ReadDataM, 0);
      @(posedge clk); #1;
      check("rstmid.idle.req", mem_req, 0);
      check("rstmid.idle.stall", StallM, 0);
      idle_inputs();
      reset = 1'b0;
      @(posedge clk); #1;
      run_access("after_rst", 1'b0, 2'b01, 3'b001, 32'h302, 32'h0, 0, 1, 32'h8001_7FFF, 1'b0);

      for (int i = 0; i < 200; i++) begin
         logic [2:0] f3;
         logic [1:0] rsrc;
         logic       we;
         int g, r;
         we   = 1'($urandom_range(0, 1));
         rsrc = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b01;
         f3   = ($urandom_range(0, 7) == 0) ? 3'($urandom) :
                (we ? 3'($urandom_range(0, 2)) : 3'({$urandom_range(0, 1), 2'b00}) |
                                                 3'($urandom_range(0, 1)));
         if (!we && $urandom_range(0, 2) == 0) f3 = 3'b010;
         g = ($urandom_range(0, 19) == 0) ? $urandom_range(15, 18) : $urandom_range(0, 3);
         r = ($urandom_range(0, 19) == 0) ? $urandom_range(15, 18) : $urandom_range(1, 3);
         run_access($sformatf("rnd%0d", i), we, rsrc, f3, $urandom, $urandom, g, r, $urandom,
                    1'($urandom_range(0, 1)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
